branch_resolve_queue: RTL and testbench
=======================================

BRANCH_RESOLVE_QUEUE -- requirements
Module: branch_resolve_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of in-flight branch predictions held (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port clear  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port push_valid  input  1  fetch issues a predicted branch this cycle.
REQ-005 SHALL have port push_ready  output  1  queue can accept a push (not full).
REQ-006 SHALL have port push_pc  input  32  PC of fetched branch.
REQ-007 SHALL have port push_hit  input  1  predictor lookup hit (predicted taken).
REQ-008 SHALL have port push_target  input  32  predicted target, valid when push_hit.
REQ-009 SHALL have port resolve_valid  input  1  execute resolves the oldest branch this cycle.
REQ-010 SHALL have port resolve_taken  input  1  actual branch direction.
REQ-011 SHALL have port resolve_target  input  32  actual taken target.
REQ-012 SHALL have port flush  input  1  external pipeline flush (exception), discards all entries.
REQ-013 SHALL have port store  output  1  one-cycle predictor-update pulse.
REQ-014 SHALL have port PC_update  output  32  PC of resolved branch.
REQ-015 SHALL have port Next_PC  output  32  actual next PC of resolved branch.
REQ-016 SHALL have port pred_result  output  1  1 = prediction was wrong.
REQ-017 SHALL have port redirect  output  1  one-cycle mispredict pulse to fetch.
REQ-018 SHALL have port redirect_pc  output  32  correct fetch PC, equal to Next_PC.
REQ-019 SHALL have port underflow  output  1  sticky: resolve seen while empty.

Function
REQ-020 SHALL store entries {pc, hit, target} in a circular buffer with rd/wr pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-021 SHALL drive push_ready = (count != DEPTH) from registered count; push with push_ready low SHALL be ignored.
REQ-022 SHALL, on resolve_valid with count>0, pop the head entry in the same cycle.
REQ-023 SHALL compute actual = resolve_taken ? resolve_target : head.pc+4 (32-bit, wrap ignored).
REQ-024 SHALL define mispredict = (head.hit != resolve_taken) | (head.hit & resolve_taken & head.target != resolve_target).
REQ-025 SHALL, one cycle after a valid resolve, pulse store=1 with PC_update=head.pc, Next_PC=actual, pred_result=mispredict, for exactly one cycle.
REQ-026 SHALL in that same cycle pulse redirect=mispredict with redirect_pc=actual.
REQ-027 SHALL, on a mispredicting resolve, discard all remaining (wrong-path) entries: count becomes 0 next cycle.
REQ-028 SHALL drop a push coinciding with a mispredicting resolve or with flush.
REQ-029 SHALL accept simultaneous push and correct resolve: count unchanged, both pointers advance.
REQ-030 SHALL on flush empty the queue next cycle, suppress any same-cycle resolve (no store, no redirect).
REQ-031 SHALL on resolve_valid with count==0 set underflow and produce no store/redirect.
REQ-032 SHALL hold PC_update, Next_PC, redirect_pc at last value when store is low.

Reset
REQ-033 SHALL on clear: count=0, pointers=0, store=0, redirect=0, pred_result=0, underflow=0, PC_update=Next_PC=redirect_pc=0.
REQ-034 SHALL give clear priority over flush, push and resolve; entry contents need not be cleared.

Configuration
REQ-035 SHALL, with BRQ_STATS_EN defined, add outputs stat_resolved[31:0] and stat_mispred[31:0], saturating counters incremented with store / store&pred_result, cleared by clear.
REQ-036 SHALL, without BRQ_STATS_EN, omit the counters and tie both outputs to 0.

Structure
REQ-037 SHALL place the entry typedef, DEPTH default, and shared predictor-state encodings (Strong_not_token..Strong_token) in package mips_bp_pkg.
REQ-038 SHALL implement storage in sub-module brq_entry_ram (DEPTH x 65-bit, one write, one async read port).

Verification
REQ-039 Push pc=0x100 hit=1 tgt=0x200; resolve taken tgt=0x200 -> next cycle store=1, PC_update=0x100, Next_PC=0x200, pred_result=0, redirect=0.
REQ-040 Push pc=0x100 hit=0; resolve taken tgt=0x180 -> store=1, pred_result=1, redirect=1, redirect_pc=0x180.
REQ-041 Push 3 entries, first mispredicts -> redirect pulse, count=0, later resolve sets underflow=1.
REQ-042 Push DEPTH entries -> push_ready=0, 5th push ignored; then push+correct resolve together -> count stays DEPTH-1+1.
REQ-043 Push pc=0x40 hit=1 tgt=0x80; resolve not-taken -> Next_PC=0x44, pred_result=1, redirect_pc=0x44.
REQ-044 Assert clear mid-stream with resolve_valid=1 -> next cycle all outputs 0, count=0, no store.

Source files
------------

// File: rtl/mips_bp_pkg.sv
// Shared branch-prediction types: queue entry layout, default depth,
// and the 2-bit predictor state encoding used across the front end.
package mips_bp_pkg;

    localparam int BRQ_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] target;
    } brq_entry_t;

    typedef enum logic [1:0] {
        Strong_not_token = 2'b00,
        Weak_not_token   = 2'b01,
        Weak_token       = 2'b10,
        Strong_token     = 2'b11
    } bp_state_t;

endpackage

// File: rtl/brq_entry_ram.sv
// Entry storage for the branch resolve queue: one synchronous write
// port and one asynchronous read port, contents are never reset.
module brq_entry_ram
    import mips_bp_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  brq_entry_t      wdata,
    input  logic [AW-1:0]   raddr,
    output brq_entry_t      rdata
);

    brq_entry_t mem [DEPTH];

    // Write the pushed entry into its slot
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue; resolves the oldest entry,
// emits predictor update and redirect. Optional BRQ_STATS_EN counters.
module branch_resolve_queue
    import mips_bp_pkg::*;
#(
    parameter int DEPTH = BRQ_DEPTH
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [31:0] push_pc,
    input  logic        push_hit,
    input  logic [31:0] push_target,
    input  logic        resolve_valid,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        flush,
    output logic        store,
    output logic [31:0] PC_update,
    output logic [31:0] Next_PC,
    output logic        pred_result,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        underflow,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispred
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    brq_entry_t    head;
    brq_entry_t    wentry;
    logic          empty;
    logic          res_ok;
    logic          mispred;
    logic          push_ok;
    logic [31:0]   actual;

    assign empty      = (count == '0);
    assign push_ready = (count != FULL);

    assign wentry.pc     = push_pc;
    assign wentry.hit    = push_hit;
    assign wentry.target = push_target;

    brq_entry_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (wentry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Evaluate the head entry against the actual branch outcome
    always_comb begin
        res_ok  = resolve_valid && !empty && !flush;
        actual  = resolve_taken ? resolve_target : head.pc + 32'd4;
        mispred = (head.hit != resolve_taken) ||
                  (head.hit && resolve_taken &&
                   (head.target != resolve_target));
        push_ok = push_valid && push_ready && !flush &&
                  !(res_ok && mispred);
    end

    // Pointer and occupancy update; mispredict or flush empties the queue
    always_ff @(posedge clk) begin
        if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush || (res_ok && mispred)) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (res_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !res_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && res_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered resolve results; PC fields hold between updates
    always_ff @(posedge clk) begin
        if (clear) begin
            store       <= 1'b0;
            redirect    <= 1'b0;
            pred_result <= 1'b0;
            underflow   <= 1'b0;
            PC_update   <= '0;
            Next_PC     <= '0;
            redirect_pc <= '0;
        end else begin
            store       <= res_ok;
            redirect    <= res_ok && mispred;
            pred_result <= res_ok && mispred;
            if (resolve_valid && empty) begin
                underflow <= 1'b1;
            end
            if (res_ok) begin
                PC_update   <= head.pc;
                Next_PC     <= actual;
                redirect_pc <= actual;
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [31:0] resolved_q;
    logic [31:0] mispred_q;

    // Saturating counts of predictor updates and mispredictions
    always_ff @(posedge clk) begin
        if (clear) begin
            resolved_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (store && (resolved_q != 32'hFFFF_FFFF)) begin
                resolved_q <= resolved_q + 32'd1;
            end
            if (store && pred_result &&
                (mispred_q != 32'hFFFF_FFFF)) begin
                mispred_q <= mispred_q + 32'd1;
            end
        end
    end

    assign stat_resolved = resolved_q;
    assign stat_mispred  = mispred_q;
`else
    assign stat_resolved = 32'd0;
    assign stat_mispred  = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed cases then
// random traffic against a queue-based reference model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        clear;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic        push_hit;
    logic [31:0] push_target;
    logic        resolve_valid;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        flush;
    logic        store;
    logic [31:0] PC_update;
    logic [31:0] Next_PC;
    logic        pred_result;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        underflow;
    logic [31:0] stat_resolved;
    logic [31:0] stat_mispred;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .clear          (clear),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_pc        (push_pc),
        .push_hit       (push_hit),
        .push_target    (push_target),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .resolve_target (resolve_target),
        .flush          (flush),
        .store          (store),
        .PC_update      (PC_update),
        .Next_PC        (Next_PC),
        .pred_result    (pred_result),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .underflow      (underflow),
        .stat_resolved  (stat_resolved),
        .stat_mispred   (stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    logic        e_store, e_redir, e_pr, e_under;
    logic [31:0] e_pcu, e_npc, e_rpc;
    logic [31:0] e_nres, e_nmis;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".store"}, 32'(store), 32'(e_store));
        chk({tag, ".redirect"}, 32'(redirect), 32'(e_redir));
        chk({tag, ".pred_result"}, 32'(pred_result), 32'(e_pr));
        chk({tag, ".underflow"}, 32'(underflow), 32'(e_under));
        chk({tag, ".PC_update"}, PC_update, e_pcu);
        chk({tag, ".Next_PC"}, Next_PC, e_npc);
        chk({tag, ".redirect_pc"}, redirect_pc, e_rpc);
        chk({tag, ".push_ready"}, 32'(push_ready),
            32'(q.size() != DEPTH));
`ifdef BRQ_STATS_EN
        chk({tag, ".stat_resolved"}, stat_resolved, e_nres);
        chk({tag, ".stat_mispred"}, stat_mispred, e_nmis);
`else
        chk({tag, ".stat_resolved"}, stat_resolved, 32'd0);
        chk({tag, ".stat_mispred"}, stat_mispred, 32'd0);
`endif
    endtask

    // One clock: update the model, drive, clock, compare.
    task automatic step(input string tag,
                        input logic pv, input logic [31:0] pc,
                        input logic hit, input logic [31:0] tgt,
                        input logic rv, input logic rt,
                        input logic [31:0] rtgt,
                        input logic fl, input logic clr);
        ent_t h;
        ent_t n;
        logic mis;
        logic [31:0] act;
        bit full;
        if (clr) begin
            q.delete();
            {e_store, e_redir, e_pr, e_under} = '0;
            {e_pcu, e_npc, e_rpc, e_nres, e_nmis} = '0;
        end else begin
            if (e_store) begin
                e_nres++;
                if (e_pr) e_nmis++;
            end
            full = (q.size() == DEPTH);
            mis = 1'b0;
            e_store = 1'b0;
            e_redir = 1'b0;
            e_pr = 1'b0;
            if (rv && q.size() == 0) e_under = 1'b1;
            if (rv && q.size() > 0 && !fl) begin
                h = q.pop_front();
                act = rt ? rtgt : h.pc + 32'd4;
                if (h.hit != rt) mis = 1'b1;
                else if (h.hit && h.tgt != rtgt) mis = 1'b1;
                e_store = 1'b1;
                e_pr = mis;
                e_redir = mis;
                e_pcu = h.pc;
                e_npc = act;
                e_rpc = act;
            end
            if (fl || mis) begin
                q.delete();
            end else if (pv && !full) begin
                n.pc = pc;
                n.hit = hit;
                n.tgt = tgt;
                q.push_back(n);
            end
        end
        push_valid = pv;
        push_pc = pc;
        push_hit = hit;
        push_target = tgt;
        resolve_valid = rv;
        resolve_taken = rt;
        resolve_target = rtgt;
        flush = fl;
        clear = clr;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] pc,
                        input logic hit, input logic [31:0] tgt);
        step(tag, 1, pc, hit, tgt, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input string tag, input logic rt,
                           input logic [31:0] rtgt);
        step(tag, 0, 0, 0, 0, 1, rt, rtgt, 0, 0);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        pv, hit, rv, rt, fl, clr;
        logic [31:0] pc, tgt, rtgt;
        {e_store, e_redir, e_pr, e_under} = '0;
        {e_pcu, e_npc, e_rpc, e_nres, e_nmis} = '0;
        @(negedge clk);
        step("reset", 0, 0, 0, 0, 1, 0, 0, 0, 1);
        idle("after_reset");

        push("t039_push", 32'h100, 1, 32'h200);
        resolve("t039_res", 1, 32'h200);
        idle("t039_hold");

        push("t040_push", 32'h100, 0, 32'h0);
        resolve("t040_res", 1, 32'h180);

        push("t043_push", 32'h40, 1, 32'h80);
        resolve("t043_res", 0, 32'h0);

        push("t041_p0", 32'h10, 0, 0);
        push("t041_p1", 32'h20, 0, 0);
        push("t041_p2", 32'h30, 0, 0);
        resolve("t041_mis", 1, 32'h500);
        resolve("t041_under", 0, 0);

        step("t042_clr", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++)
            push("t042_fill", 32'h1000 + 32'(i * 16), 0, 0);
        push("t042_over", 32'h2000, 0, 0);
        step("t042_full_pr", 1, 32'h2100, 0, 0, 1, 0, 0, 0, 0);
        step("t042_pr", 1, 32'h2200, 1, 32'h3000, 1, 0, 0, 0, 0);
        step("t042_pr2", 1, 32'h2300, 0, 0, 1, 0, 0, 0, 0);

        step("t044_clr", 1, 32'h77, 0, 0, 1, 1, 32'h9, 1, 1);
        idle("t044_after");

        push("fl_p0", 32'h600, 1, 32'h700);
        push("fl_p1", 32'h610, 0, 0);
        step("fl_both", 1, 32'h620, 0, 0, 1, 1, 32'h700, 1, 0);
        resolve("fl_under", 1, 32'h0);

        step("rnd_clr", 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            pv = ($urandom_range(0, 99) < 55);
            pc = {$urandom_range(0, 255), 2'b00};
            hit = $urandom_range(0, 1);
            tgt = {$urandom_range(0, 3), 8'h00};
            rv = ($urandom_range(0, 99) < 40);
            rt = $urandom_range(0, 1);
            rtgt = {$urandom_range(0, 3), 8'h00};
            if (q.size() > 0 && $urandom_range(0, 99) < 60) begin
                rt = q[0].hit;
                rtgt = q[0].tgt;
            end
            fl = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 199) < 1);
            step("rnd", pv, pc, hit, tgt, rv, rt, rtgt, fl, clr);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
